rx_lanes_fifo: RTL and testbench
================================

Name: rx_lanes_fifo

Overview:
Parametrised multi-lane serial receiver for router input ports. Frames arrive LSB-first over LANES parallel serial wires and are framed by a start bit. An optional even-parity bit follows the data. Completed items go into a DEPTH-entry output FIFO that the router crossbar drains with a valid/item_read handshake. channel_busy gives the upstream transmitter link-level backpressure.

Parameters:
DATA_W, 16, item width in bits (payload+address); must be a multiple of LANES
LANES, 4, serial lanes per channel; 1 gives the classic single-wire link
DEPTH, 4, output FIFO entries; power of two, >= 2
PARITY_EN, 1, 1 = one parity beat follows the data beats; 0 = none
ROUTERID, -1, simulation identifier only; no effect on logic

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
serial_in  in  LANES  serial lanes; lane k carries bit (beat*LANES+k)
item_read  in  1  consumer pops the FIFO head this cycle (honoured only when valid=1)
valid  out  1  FIFO not empty
parallel_out  out  DATA_W  FIFO head item
parity_err  out  1  parity-error flag stored with the FIFO head item (0 when PARITY_EN=0)
channel_busy  out  1  high when state != IDLE or FIFO full; sender must not start a frame while high
drop_cnt  out  8  saturating count of frames discarded because they started while the FIFO was full

Behaviour:
- BEATS = DATA_W/LANES. A frame is one start beat (serial_in[0]=1; other lanes don't-care), then BEATS data beats, then one parity beat on lane 0 if PARITY_EN. The parity bit is the XOR of all DATA_W data bits.
- States: IDLE, RECV, PAR, DISCARD. Beat counter is ceil(log2(BEATS+1)) bits wide.
- IDLE: serial_in[0]=1 and FIFO not full -> RECV, beat counter cleared. serial_in[0]=1 and FIFO full -> DISCARD, drop_cnt += 1, saturating at 255. Otherwise stay in IDLE.
- RECV: each cycle, shift register [beat*LANES +: LANES] <= serial_in, and the beat counter increments. The last beat goes to PAR if PARITY_EN, else pushes and goes to IDLE.
- PAR: compute perr = serial_in[0] ^ (XOR of the shift register). Push {perr, item} and go to IDLE.
- DISCARD: consume BEATS+PARITY_EN beats ignoring data, then go to IDLE. No push.
- Push happens at the clock edge that samples the final beat. valid rises in the next cycle. Latency from the start beat to valid is BEATS+PARITY_EN+1 cycles.
- A new start beat is accepted in the cycle immediately after the final beat, so back-to-back frames run with no gap.
- FIFO: registered memory with wrapping read/write pointers and a count of 0..DEPTH.
  - parallel_out and parity_err are driven combinationally from the read pointer.
  - Pop occurs when valid & item_read.
  - Push and pop in the same cycle leave count unchanged. This is legal at any count, including full.
  - Push never finds the FIFO full, because the frame started while it was not full and only one frame is in flight.
  - item_read while empty is ignored.
- channel_busy = (state != IDLE) | (count == DEPTH), combinational.
- Shift register is cleared on entry to RECV, so no stale bits carry over between frames.
- Reset, asynchronous, valid at any point including mid-frame:
  - state=IDLE, pointers=0, count=0, shift register=0, drop_cnt=0.
  - Outputs: valid=0, channel_busy=0, parallel_out=0, parity_err=0.
  - A partially received frame is lost. The first cycle after reset deassertion may carry a start beat.
- FIFO memory contents need not be reset, but parallel_out must read 0 while empty after reset; gate parallel_out with valid.

Test Plan:
1. Defaults; start beat, then lanes 0x3, 0xC, 0x5, 0xA, then parity 0 -> 6 cycles after the start beat: valid=1, parallel_out=0xA5C3, parity_err=0; channel_busy high for the 5 beats after the start beat.
2. Same frame with parity bit 1 -> item 0xA5C3 delivered with parity_err=1; drop_cnt stays 0.
3. Four back-to-back frames 0x0001, 0x0002, 0x0003, 0x0004 with item_read=0 -> FIFO full, channel_busy stays 1 in IDLE. A fifth start beat -> DISCARD for 5 cycles, drop_cnt=1. Then 4 pops return 0x0001..0x0004 in order, and valid=0 afterwards.
4. FIFO holding 3 items, with a pop in the same cycle as a push -> count stays 3, order preserved, no item lost or duplicated.
5. Assert reset after 2 data beats of a frame -> all outputs 0 immediately (asynchronous). Next frame 0x1234 received correctly.
6. DATA_W=8, LANES=1, PARITY_EN=0; serial 1, then 1,0,1,1,0,0,1,0 -> parallel_out=0x4D, valid 9 cycles after the start beat.

Source files
------------

// File: rtl/rx_lanes_fifo.sv
// rx_lanes_fifo: multi-lane start-bit framed serial receiver with optional even parity feeding a DEPTH-entry output FIFO.
module rx_lanes_fifo #(
  parameter int DATA_W    = 16,
  parameter int LANES     = 4,
  parameter int DEPTH     = 4,
  parameter int PARITY_EN = 1,
  parameter int ROUTERID  = -1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LANES-1:0]  serial_in,
  input  logic              item_read,
  output logic              valid,
  output logic [DATA_W-1:0] parallel_out,
  output logic              parity_err,
  output logic              channel_busy,
  output logic [7:0]        drop_cnt
);
  localparam int BEATS = DATA_W / LANES;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] LAST_DISC = CNT_W'(BEATS + PARITY_EN - 1);
  typedef enum logic [1:0] {IDLE, RECV, PAR, DISCARD} state_t;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic [DATA_W:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [PTR_W:0]    r_count;
  logic              w_full, w_push, w_pop, w_perr;
  logic [DATA_W:0]   w_wdata, w_head;
  // ROUTERID only tags instances in simulation hierarchies
  if (ROUTERID < -1) begin : g_routerid
  end
  always_comb begin
    w_shift_nxt = r_shift;
    for (int b = 0; b < BEATS; b++)
      if (r_cnt == CNT_W'(b)) w_shift_nxt[b*LANES +: LANES] = serial_in;
  end
  assign w_perr       = (PARITY_EN != 0) & (serial_in[0] ^ (^r_shift));
  assign w_push       = (r_state == RECV && r_cnt == LAST_DATA && PARITY_EN == 0) || r_state == PAR;
  assign w_wdata      = r_state == PAR ? {w_perr, r_shift} : {1'b0, w_shift_nxt};
  assign w_full       = r_count == (PTR_W+1)'(DEPTH);
  assign valid        = r_count != '0;
  assign w_pop        = valid & item_read;
  assign w_head       = r_mem[r_rptr];
  assign parallel_out = valid ? w_head[DATA_W-1:0] : '0;
  assign parity_err   = valid & w_head[DATA_W];
  assign channel_busy = (r_state != IDLE) | w_full;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      drop_cnt <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE: if (serial_in[0]) begin
          r_cnt <= '0;
          if (w_full) begin
            r_state  <= DISCARD;
            drop_cnt <= drop_cnt + {7'd0, drop_cnt != 8'hFF};
          end else begin
            r_state <= RECV;
            r_shift <= '0;
          end
        end
        RECV: begin
          r_shift <= w_shift_nxt;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_DATA) r_state <= PARITY_EN != 0 ? PAR : IDLE;
        end
        PAR: r_state <= IDLE;
        DISCARD: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_DISC) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push != w_pop) r_count <= w_push ? r_count + 1'b1 : r_count - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_wdata;
  end
endmodule

// File: tb/tb_rx_lanes_fifo.sv
// tb_rx_lanes_fifo: directed-vector bench for rx_lanes_fifo (default 16b/4-lane/parity, plus an 8b single-lane no-parity instance).
module tb_rx_lanes_fifo;
  logic        clk = 0, reset = 1;
  logic [3:0]  serial_in = '0;
  logic        item_read = 0;
  logic        valid, parity_err, channel_busy;
  logic [15:0] parallel_out;
  logic [7:0]  drop_cnt;
  logic [0:0]  s8 = '0;
  logic        item_read8 = 0;
  logic        valid8, perr8, busy8;
  logic [7:0]  out8, drop8;
  int n_vec = 0, n_err = 0;

  rx_lanes_fifo u_dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .item_read(item_read),
    .valid(valid), .parallel_out(parallel_out), .parity_err(parity_err),
    .channel_busy(channel_busy), .drop_cnt(drop_cnt));

  rx_lanes_fifo #(.DATA_W(8), .LANES(1), .DEPTH(4), .PARITY_EN(0), .ROUTERID(7)) u_dut8 (
    .clk(clk), .reset(reset), .serial_in(s8), .item_read(item_read8),
    .valid(valid8), .parallel_out(out8), .parity_err(perr8),
    .channel_busy(busy8), .drop_cnt(drop8));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] item, input logic pbit, input logic pop_last, input logic lat);
    serial_in = 4'b0001;
    tick;
    for (int b = 0; b < 4; b++) begin
      chk("busy_beat", channel_busy, 1);
      serial_in = item[4*b +: 4];
      tick;
    end
    chk("busy_par", channel_busy, 1);
    if (lat) chk("valid_early", valid, 0);
    serial_in = {3'b000, pbit};
    item_read = pop_last;
    tick;
    item_read = 0;
    serial_in = '0;
  endtask

  task automatic pop(input logic [15:0] exp, input logic eperr);
    chk("pop_valid", valid, 1);
    chk("pop_data", parallel_out, exp);
    chk("pop_perr", parity_err, eperr);
    item_read = 1;
    tick;
    item_read = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_data", parallel_out, 0);
    chk("rst_busy", channel_busy, 0);
    chk("rst_drop", drop_cnt, 0);
    tick;
    reset = 0;
    // 1: good frame, latency 6 cycles
    send(16'hA5C3, 1'b0, 0, 1);
    chk("t1_valid", valid, 1);
    chk("t1_busy", channel_busy, 0);
    pop(16'hA5C3, 0);
    chk("t1_empty", valid, 0);
    // 2: bad parity
    send(16'hA5C3, 1'b1, 0, 1);
    pop(16'hA5C3, 1);
    chk("t2_drop", drop_cnt, 0);
    // 3: fill, discard, drain
    send(16'h0001, 1'b1, 0, 0);
    send(16'h0002, 1'b1, 0, 0);
    send(16'h0003, 1'b0, 0, 0);
    send(16'h0004, 1'b1, 0, 0);
    chk("t3_full_busy", channel_busy, 1);
    serial_in = 4'b0001;
    tick;
    chk("t3_drop", drop_cnt, 1);
    serial_in = 4'hF;
    repeat (5) tick;
    serial_in = '0;
    chk("t3_busy_after", channel_busy, 1);
    chk("t3_head", parallel_out, 16'h0001);
    pop(16'h0001, 0);
    chk("t3_busy_free", channel_busy, 0);
    pop(16'h0002, 0);
    pop(16'h0003, 0);
    pop(16'h0004, 0);
    chk("t3_empty", valid, 0);
    chk("t3_zero", parallel_out, 0);
    // 4: push and pop on same edge with 3 stored
    send(16'h0011, 1'b0, 0, 0);
    send(16'h0022, 1'b0, 0, 0);
    send(16'h0033, 1'b0, 0, 0);
    send(16'h0044, 1'b0, 1, 0);
    chk("t4_busy", channel_busy, 0);
    pop(16'h0022, 0);
    pop(16'h0033, 0);
    pop(16'h0044, 0);
    chk("t4_empty", valid, 0);
    // 5: async reset mid-frame
    send(16'h00AA, 1'b0, 0, 0);
    chk("t5_pre_valid", valid, 1);
    serial_in = 4'b0001;
    tick;
    serial_in = 4'h5;
    tick;
    serial_in = 4'h6;
    tick;
    #2 reset = 1;
    #1;
    chk("t5_valid", valid, 0);
    chk("t5_data", parallel_out, 0);
    chk("t5_perr", parity_err, 0);
    chk("t5_busy", channel_busy, 0);
    chk("t5_drop", drop_cnt, 0);
    tick;
    reset = 0;
    serial_in = '0;
    send(16'h1234, 1'b1, 0, 1);
    pop(16'h1234, 0);
    // 6: 8-bit single lane, no parity
    pat = 8'h4D;
    chk("t6_idle", valid8, 0);
    s8 = 1'b1;
    tick;
    for (int b = 0; b < 8; b++) begin
      chk("t6_early", valid8, 0);
      chk("t6_busy", busy8, 1);
      s8 = pat[b];
      tick;
    end
    s8 = '0;
    chk("t6_valid", valid8, 1);
    chk("t6_data", out8, 8'h4D);
    chk("t6_perr", perr8, 0);
    chk("t6_drop", drop8, 0);
    chk("t6_busy_end", busy8, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
